// File: rtl/icache_intc_rr_req_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one I-cache bank port among N_CORES fetch ports,
// with a registered output slot and one outstanding fetch per core.
module icache_intc_rr_req_arbiter #(
  parameter int N_CORES       = 8,
  parameter int ADDRESS_WIDTH = 32,
  parameter int UID_WIDTH     = N_CORES
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [N_CORES-1:0]                      request_i,
  input  logic [N_CORES-1:0][ADDRESS_WIDTH-1:0]   address_i,
  input  logic [N_CORES-1:0][UID_WIDTH-1:0]       UID_i,
  output logic [N_CORES-1:0]                      grant_o,
  output logic                                    request_o,
  output logic [ADDRESS_WIDTH-1:0]                address_o,
  output logic [UID_WIDTH-1:0]                    UID_o,
  input  logic                                    grant_i,
  input  logic                                    response_i,
  input  logic [UID_WIDTH-1:0]                    response_UID_i,
  output logic [N_CORES-1:0]                      response_o
);

  localparam int              PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [PTR_W:0]  N_L   = N_CORES[PTR_W:0];
  localparam logic [PTR_W:0]  ONE_L = {{PTR_W{1'b0}}, 1'b1};

  logic                     valid_q, valid_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [UID_WIDTH-1:0]     uid_q, uid_d;
  logic [N_CORES-1:0]       pending_q, pending_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;

  logic                     slot_free;
  logic [N_CORES-1:0]       elig;
  logic                     win_found;
  logic [PTR_W-1:0]         win_idx;
  logic [PTR_W:0]           cand;
  logic [PTR_W:0]           ptr_next;
  logic [N_CORES-1:0]       win_onehot;
  logic                     do_grant;

  assign slot_free = ~valid_q | grant_i;
  assign elig      = request_i & ~pending_q;

  // Scan from rr_ptr_q upward, wrapping modulo N_CORES; first eligible core wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_CORES; k++) begin
      cand = {1'b0, rr_ptr_q} + k[PTR_W:0];
      if (cand >= N_L) cand = cand - N_L;
      if (!win_found && elig[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // Gated by rst_ni so no core sees an accept while the block is held in reset.
  assign do_grant = rst_ni & slot_free & win_found;
  assign grant_o  = do_grant ? win_onehot : '0;

  always_comb begin
    ptr_next = {1'b0, win_idx} + ONE_L;
    if (ptr_next >= N_L) ptr_next = '0;
  end

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    uid_d    = uid_q;
    rr_ptr_d = rr_ptr_q;
    if (do_grant) begin
      valid_d  = 1'b1;
      addr_d   = address_i[win_idx];
      uid_d    = UID_i[win_idx];
      rr_ptr_d = ptr_next[PTR_W-1:0];
    end else if (grant_i) begin
      valid_d  = 1'b0;
    end
  end

  // Clear before set: a response and a re-grant on the same core leave it pending.
  always_comb begin
    pending_d = pending_q & ~response_o;
    if (do_grant) pending_d = pending_d | win_onehot;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      uid_q     <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      uid_q     <= uid_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign request_o  = valid_q;
  assign address_o  = addr_q;
  assign UID_o      = uid_q;
  assign response_o = {N_CORES{response_i}} & response_UID_i;

endmodule

// File: tb/tb_icache_intc_rr_req_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for the round-robin I-cache request arbiter (4 cores):
// a reference model predicts grants and queues expected bank transfers.
module tb_icache_intc_rr_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          request_i;
  logic [N-1:0][AW-1:0]  address_i;
  logic [N-1:0][N-1:0]   UID_i;
  logic [N-1:0]          grant_o;
  logic                  request_o;
  logic [AW-1:0]         address_o;
  logic [N-1:0]          UID_o;
  logic                  grant_i;
  logic                  response_i;
  logic [N-1:0]          response_UID_i;
  logic [N-1:0]          response_o;

  always #5 clk = ~clk;

  icache_intc_rr_req_arbiter #(.N_CORES(N), .ADDRESS_WIDTH(AW), .UID_WIDTH(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .request_i(request_i), .address_i(address_i),
    .UID_i(UID_i), .grant_o(grant_o), .request_o(request_o), .address_o(address_o),
    .UID_o(UID_o), .grant_i(grant_i), .response_i(response_i),
    .response_UID_i(response_UID_i), .response_o(response_o)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [N-1:0]  u;
  } item_t;
  item_t sb[$];
  item_t mon_e;

  // Reference model: occupancy of the bank slot, per-core outstanding flag, RR pointer.
  bit            m_valid;
  bit [N-1:0]    m_pend;
  int            m_ptr;
  logic [N-1:0]  m_uid;
  bit            n_valid;
  bit [N-1:0]    n_pend;
  int            n_ptr;
  logic [N-1:0]  n_uid;

  // Bank responder used in the randomized phases.
  bit env_on;
  int due[N];
  bit outst[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_pend = '0; m_ptr = 0; m_uid = '0;
    sb.delete();
    for (int i = 0; i < N; i++) begin due[i] = 0; outst[i] = 0; end
  endtask

  task automatic env_drive();
    response_i = 1'b0;
    response_UID_i = '0;
    for (int i = 0; i < N; i++) begin
      if (env_on && outst[i] && due[i] <= 0 && !response_i) begin
        response_i = 1'b1;
        response_UID_i = N'(1 << i);
        outst[i] = 0;
      end
    end
  endtask

  // One clock: predict at the falling edge, commit model state at the rising edge.
  task automatic step();
    int  w;
    int  idx;
    bit  sf;
    @(negedge clk);
    sf = !m_valid || grant_i;
    w = -1;
    if (sf) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && request_i[idx] && !m_pend[idx]) w = idx;
      end
    end
    chk("grant_o", grant_o, (w < 0) ? 0 : (1 << w));
    chk("request_o", request_o, m_valid);
    chk("response_o", response_o, response_i ? response_UID_i : '0);
    n_valid = m_valid; n_ptr = m_ptr; n_uid = m_uid;
    n_pend = m_pend & ~(response_i ? response_UID_i : '0);
    if (env_on && m_valid && grant_i) begin
      for (int i = 0; i < N; i++) begin
        if (m_uid[i]) begin outst[i] = 1; due[i] = int'($urandom_range(1, 3)); end
      end
    end
    if (w >= 0) begin
      n_pend[w] = 1'b1;
      n_valid = 1;
      n_ptr = (w + 1) % N;
      n_uid = UID_i[w];
      sb.push_back('{a: address_i[w], u: UID_i[w]});
    end else if (grant_i) begin
      n_valid = 0;
    end
    @(posedge clk);
    m_valid = n_valid; m_pend = n_pend; m_ptr = n_ptr; m_uid = n_uid;
    for (int i = 0; i < N; i++) due[i]--;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    request_i = '0; grant_i = 1'b0; response_i = 1'b0; response_UID_i = '0;
    env_on = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every accepted bank transfer must match the oldest predicted grant.
  always @(negedge clk) begin
    if (rst_n && request_o && grant_i) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty: bank accepted addr %0h uid %0h with nothing expected", address_o, UID_o);
      end else begin
        mon_e = sb.pop_front();
        chk("address_o", address_o, mon_e.a);
        chk("UID_o", UID_o, mon_e.u);
      end
    end
  end

  initial begin
    request_i = '0; grant_i = 1'b0; response_i = 1'b0; response_UID_i = '0;
    env_on = 0;
    for (int i = 0; i < N; i++) begin
      UID_i[i] = N'(1 << i);
      address_i[i] = '0;
    end
    model_clear();

    // Held in reset with every core requesting: nothing may be granted.
    request_i = '1;
    #2;
    chk("grant_in_reset", grant_o, '0);
    chk("request_in_reset", request_o, 1'b0);
    do_reset();

    // Idle after reset.
    repeat (10) begin
      step();
      chk("idle_address_o", address_o, '0);
      chk("idle_UID_o", UID_o, '0);
    end

    // All four cores requesting, bank always ready, responses from the responder.
    env_on = 1;
    for (int i = 0; i < N; i++) address_i[i] = 32'h100 * (i + 1);
    request_i = 4'b1111; grant_i = 1'b1;
    repeat (20) begin env_drive(); step(); end
    do_reset();

    // Core 2 alone, bank stalls five cycles.
    request_i = 4'b0100; address_i[2] = 32'h1000_0040; grant_i = 1'b0;
    step();
    repeat (5) begin
      step();
      chk("stall_request_o", request_o, 1'b1);
      chk("stall_address_o", address_o, 32'h1000_0040);
    end
    grant_i = 1'b1;
    step();
    step();
    chk("drained_request_o", request_o, 1'b0);
    do_reset();

    // Core 1 blocked while outstanding, re-granted after its response.
    request_i = 4'b0010; address_i[1] = 32'hABCD_0010; grant_i = 1'b1;
    repeat (5) step();
    response_i = 1'b1; response_UID_i = 4'b0010;
    step();
    response_i = 1'b0; response_UID_i = '0;
    step();
    step();
    do_reset();

    // Core 3: stale response in the same cycle as its grant keeps it pending.
    request_i = 4'b1000; address_i[3] = 32'h0000_3300; grant_i = 1'b1;
    response_i = 1'b1; response_UID_i = 4'b1000;
    step();
    response_i = 1'b0; response_UID_i = '0;
    repeat (4) step();
    response_i = 1'b1; response_UID_i = 4'b1000;
    step();
    response_i = 1'b0; response_UID_i = '0;
    step();
    do_reset();

    // Asynchronous reset with a full slot and cores 0 and 2 pending.
    for (int i = 0; i < N; i++) address_i[i] = 32'h2000_0000 + 32'(i);
    request_i = 4'b0101; grant_i = 1'b0;
    step();
    grant_i = 1'b1;
    step();
    chk("pre_reset_request_o", request_o, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_request_o", request_o, 1'b0);
    chk("async_reset_grant_o", grant_o, '0);
    model_clear();
    request_i = 4'b1111;
    @(posedge clk);
    #1 rst_n = 1'b1;
    response_i = 1'b1; response_UID_i = 4'b0100;
    step();
    response_i = 1'b0; response_UID_i = '0;
    repeat (4) step();
    do_reset();

    // Randomized traffic with random bank back-pressure.
    env_on = 1;
    repeat (600) begin
      request_i = N'($urandom);
      for (int i = 0; i < N; i++) address_i[i] = $urandom;
      grant_i = ($urandom_range(0, 3) != 0);
      env_drive();
      step();
    end
    request_i = '0; grant_i = 1'b1;
    repeat (8) begin env_drive(); step(); end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_intc_rr_req_arbiter.md
Name: icache_intc_rr_req_arbiter

Overview:
- Pipelined round-robin request arbiter for the instruction-cache interconnect. It shares one cache-bank request port among N_CORES fetch ports.
- It adds a registered output slot, so request_o/address_o/UID_o are flop outputs and stay stable until granted.
- It allows at most one outstanding fetch per core, tracked by a pending mask that is cleared on the matching response.
- Sits between the core fetch ports and one cache bank. It replaces a purely combinational arbitration tree when timing requires a register stage.

Parameters:
- N_CORES, 8, number of requesting fetch ports (>=1)
- ADDRESS_WIDTH, 32, fetch address width
- UID_WIDTH, N_CORES, one-hot requester ID width; must equal N_CORES

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- request_i  in  N_CORES  per-core fetch request
- address_i  in  N_CORES x ADDRESS_WIDTH  per-core fetch address
- UID_i  in  N_CORES x UID_WIDTH  per-core one-hot ID
- grant_o  out  N_CORES  per-core accept, one-hot or zero
- request_o  out  1  bank request (registered)
- address_o  out  ADDRESS_WIDTH  bank address (registered)
- UID_o  out  UID_WIDTH  bank-side ID (registered)
- grant_i  in  1  bank accepts the current request_o
- response_i  in  1  bank response valid
- response_UID_i  in  UID_WIDTH  one-hot ID of the response
- response_o  out  N_CORES  per-core response strobe

Behaviour:
- Reset (async, rst_ni=0):
  - valid_q=0, addr_q=0, uid_q=0, pending_q=0, rr_ptr_q=0.
  - request_o=0, address_o=0, UID_o=0. grant_o=0 while in reset.
- Output slot:
  - request_o=valid_q, address_o=addr_q, UID_o=uid_q.
  - Once valid_q=1, addr_q and uid_q hold until the cycle with request_o&grant_i.
- Slot free condition: slot_free = ~valid_q | grant_i. The slot can reload in the same cycle it drains, so throughput is 1 request/cycle while grant_i is held high.
- Eligibility: elig = request_i & ~pending_q.
- Arbitration (combinational, only when slot_free):
  - Winner w = first set bit of elig, scanning from index rr_ptr_q upward and wrapping modulo N_CORES.
  - grant_o[w]=1 in that cycle; all other grant_o bits are 0.
  - If elig=0 or slot not free: grant_o=0.
- On a grant (next edge):
  - valid_q=1, addr_q=address_i[w], uid_q=UID_i[w].
  - rr_ptr_q=(w+1) mod N_CORES.
  - pending_q[w] set.
- On a drain without a new grant (request_o&grant_i and no winner): valid_q=0.
- Latency: 1 cycle from grant_o[w] to request_o carrying that address. Nothing is forwarded combinationally from request_i to request_o.
- Pointer: rr_ptr_q advances only on a grant and is unchanged in idle cycles. With N_CORES=1, rr_ptr_q stays 0.
- Response path:
  - response_o = {N_CORES{response_i}} & response_UID_i, purely combinational.
  - pending_q[i] is cleared on the edge where response_i & response_UID_i[i].
- Simultaneous clear and set on the same core in one cycle (response for the old fetch, grant for the new one): pending_q[i] ends at 1.
- A response for a core whose pending bit is already 0 is passed through on response_o and leaves pending_q unchanged.
- grant_i while valid_q=0 is ignored.
- Reset mid-operation discards the slot contents and all pending bits immediately. Responses arriving after reset still appear on response_o and have no effect on pending_q.
- A core that drops request_i before being granted simply loses eligibility. No state is kept for it.

Test Plan:
- Reset then idle, with request_i=0:
  - Required: request_o=0, grant_o=0, address_o=0, UID_o=0 for 10 cycles.
- N_CORES=4, request_i=4'b1111, grant_i=1, each core responding 2 cycles after its grant:
  - Required grant order: cores 0,1,2,3,0,1…
  - request_o is high every cycle from cycle 1, and address_o tracks the granted core one cycle later.
- Core 2 alone, address 0x1000_0040, grant_i held 0 for 5 cycles, then 1:
  - Required: grant_o=4'b0100 once.
  - request_o=1 with address_o=0x1000_0040 stable for all 6 cycles, then request_o=0.
- Core 1 granted, no response yet, request_i[1] still high:
  - Required: grant_o[1] stays 0.
- Core 1 then receives response_i=1 with response_UID_i=4'b0010:
  - Required: response_o=4'b0010.
  - Core 1 becomes eligible and is granted the next cycle.
- Core 3 receives its response in the same cycle it is re-granted:
  - Required: pending_q[3]=1 afterwards, and a further request from core 3 is blocked until its next response.
- rst_ni pulsed low asynchronously while valid_q=1 and pending_q=4'b0101:
  - Required: request_o drops immediately, pending_q=0, rr_ptr_q=0.
  - After release, core 0 wins first when all cores request.
